// File: rtl/world_map_arbiter.sv
// world_map_arbiter: shares one single-port world-map RAM between the video
// pixel fetch (absolute priority, fixed 2-cycle latency) and a processor
// requester. A one-entry last-cell cache turns repeated video fetches of the
// same cell into free RAM slots for the processor.
// Optional: define ARB_STALL_CNT_EN to add the stall_count output.
module world_map_arbiter #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_valid,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]   stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_cache_valid;
  logic [AW-1:0] r_cache_addr;
  logic [DW-1:0] r_cache_data;
  logic          r_s1_valid;
  logic          r_s1_hit;
  logic          r_vid_valid;
  logic [DW-1:0] r_vid_data;
  logic          r_cpu_ack;
  logic [DW-1:0] r_cpu_rdata;

  logic          w_hit;
  logic          w_miss;
  logic          w_grant;
  logic          w_cache_wr;

  // Hit/miss classification and processor grant (video misses own the RAM)
  assign w_hit      = vid_req & r_cache_valid & (vid_addr == r_cache_addr);
  assign w_miss     = vid_req & ~w_hit;
  assign w_grant    = (r_state == IDLE) & cpu_req & ~w_miss;
  assign w_cache_wr = w_grant & cpu_we & r_cache_valid & (cpu_addr == r_cache_addr);

  // RAM port is driven in the issue cycle; held idle while in reset
  assign mem_en    = sys_rst & (w_miss | w_grant);
  assign mem_we    = sys_rst & w_grant & cpu_we;
  assign mem_addr  = w_miss ? vid_addr : cpu_addr;
  assign mem_wdata = cpu_wdata;

  assign vid_valid = r_vid_valid;
  assign vid_data  = r_vid_data;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;

  // Processor FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = cpu_we ? RESP : RD_WAIT;
      RD_WAIT: w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Processor FSM state register, ack pulse and read-data capture
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state     <= IDLE;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cpu_ack <= (w_state_nxt == RESP);
      if (r_state == RD_WAIT) r_cpu_rdata <= mem_rdata;
    end
  end

  // Video pipeline: stage 1 remembers hit/miss, stage 2 delivers the cell
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_hit    <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
    end else begin
      r_s1_valid  <= vid_req;
      r_s1_hit    <= w_hit;
      r_vid_valid <= r_s1_valid;
      if (r_s1_valid) r_vid_data <= r_s1_hit ? r_cache_data : mem_rdata;
    end
  end

  // Last-cell cache; a coherent processor write beats a miss fill
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cache_valid <= 1'b0;
      r_cache_addr  <= '0;
      r_cache_data  <= '0;
    end else begin
      if (w_miss) begin
        r_cache_valid <= 1'b1;
        r_cache_addr  <= vid_addr;
      end
      if (w_cache_wr)                   r_cache_data <= cpu_wdata;
      else if (r_s1_valid && !r_s1_hit) r_cache_data <= mem_rdata;
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] r_stall_count;

  // Saturating count of cycles a processor request waits in IDLE
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_stall_count <= 16'd0;
    end else if ((r_state == IDLE) && cpu_req && !w_grant && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_world_map_arbiter.sv
// Bench for world_map_arbiter: a RAM model, an abstract reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_world_map_arbiter;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]   stall_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  world_map_arbiter #(.AW(AW), .DW(DW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Single-port synchronous RAM
  logic [DW-1:0] ram   [0:8191];
  logic [DW-1:0] m_mem [0:8191];

  always @(posedge sys_clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) ram[mem_addr] = mem_wdata;
      else                 mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the map seen by video is the RAM contents after any
  // write granted in the same cycle; the processor completes 1 (write) or
  // 2 (read) cycles after the first cycle the RAM is free while it waits.
  bit            m_cv = 1'b0;
  logic [AW-1:0] m_ca = '0;
  logic          m_vv = 1'b0, p_v = 1'b0;
  logic [DW-1:0] m_vd = '0, p_d = '0, m_rd = '0, m_rd_val = '0;
  bit            m_is_rd = 1'b0;
  int            m_ack_cyc = -10;
  int            cyc = 0;
  bit            hit, miss, grant, idle;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      m_cv = 1'b0; m_vv = 1'b0; m_vd = '0; p_v = 1'b0;
      m_rd = '0; m_ack_cyc = -10; m_is_rd = 1'b0;
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_vid_valid", 32'(vid_valid), 0);
      chk("rst_vid_data", 32'(vid_data), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    end else begin
      hit   = vid_req && m_cv && (vid_addr == m_ca);
      miss  = vid_req && !hit;
      idle  = cyc > m_ack_cyc;
      grant = idle && cpu_req && !miss;
      chk("mem_en", 32'(mem_en), 32'(miss || grant));
      if (miss) begin
        chk("mem_addr_vid", 32'(mem_addr), 32'(vid_addr));
        chk("mem_we_vid", 32'(mem_we), 0);
      end else if (grant) begin
        chk("mem_we_cpu", 32'(mem_we), 32'(cpu_we));
        chk("mem_addr_cpu", 32'(mem_addr), 32'(cpu_addr));
        if (cpu_we) chk("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
      end
      chk("vid_valid", 32'(vid_valid), 32'(m_vv));
      chk("vid_data", 32'(vid_data), 32'(m_vd));
      chk("cpu_ack", 32'(cpu_ack), 32'(cyc == m_ack_cyc));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rd));
      if (grant) begin
        if (cpu_we) m_mem[cpu_addr] = cpu_wdata;
        else        m_rd_val = m_mem[cpu_addr];
        m_is_rd   = !cpu_we;
        m_ack_cyc = cyc + (cpu_we ? 1 : 2);
      end
      if (m_is_rd && (cyc + 1 == m_ack_cyc)) m_rd = m_rd_val;
      m_vv = p_v;
      if (p_v) m_vd = p_d;
      p_v = vid_req;
      if (vid_req) p_d = m_mem[vid_addr];
      if (miss) begin
        m_cv = 1'b1;
        m_ca = vid_addr;
      end
    end
    cyc++;
  end

  // Requester side: drop cpu_req the cycle after the ack
  bit cpu_done = 1'b0;
  bit dropped  = 1'b0;

  always @(negedge sys_clk) begin
    if (sys_rst && cpu_ack === 1'b1) cpu_done = 1'b1;
  end

  task automatic tick(input logic v, input logic [AW-1:0] a);
    @(posedge sys_clk);
    #1;
    dropped = 1'b0;
    if (cpu_done) begin
      cpu_req  = 1'b0;
      cpu_done = 1'b0;
      dropped  = 1'b1;
    end
    vid_req  = v;
    vid_addr = a;
  endtask

  task automatic smp();
    @(negedge sys_clk);
  endtask

  task automatic cpu_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  task automatic wait_ack(input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick(1'b0, '0);
      got = dropped;
    end
    chk(nm, 32'(got), 1);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i]   = 8'(i ^ 32'hA5);
      m_mem[i] = 8'(i ^ 32'hA5);
    end
    ram[13'h010] = 8'h5A; m_mem[13'h010] = 8'h5A;
    ram[13'h020] = 8'h33; m_mem[13'h020] = 8'h33;
    ram[13'h030] = 8'h11; m_mem[13'h030] = 8'h11;

    // Reset holds the RAM port idle even with a video request present
    tick(1'b1, 13'h010);
    smp();
    chk("lit_rst_mem_en", 32'(mem_en), 0);
    chk("lit_rst_vid_valid", 32'(vid_valid), 0);
    tick(1'b0, '0);
    sys_rst = 1'b1;

    // Four fetches of one cell: one RAM read, four deliveries
    for (int i = 0; i < 6; i++) begin
      tick(i < 4, 13'h010);
      smp();
      chk("lit_s1_mem_en", 32'(mem_en), 32'(i == 0));
      if (i >= 2) begin
        chk("lit_s1_vid_valid", 32'(vid_valid), 1);
        chk("lit_s1_vid_data", 32'(vid_data), 32'h5A);
      end
    end

    // Fresh cache: processor read granted in the first hit cycle
    tick(1'b0, '0); sys_rst = 1'b0;
    tick(1'b0, '0);
    tick(1'b0, '0); sys_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(i < 4, 13'h010);
      if (i == 0) cpu_start(1'b0, 13'h020, 8'h00);
      smp();
      if (i == 0) chk("lit_s2_miss_addr", 32'(mem_addr), 32'h010);
      if (i == 1) begin
        chk("lit_s2_grant_en", 32'(mem_en), 1);
        chk("lit_s2_grant_addr", 32'(mem_addr), 32'h020);
      end
      if (i == 2) chk("lit_s2_no_ack", 32'(cpu_ack), 0);
      if (i == 3) begin
        chk("lit_s2_ack", 32'(cpu_ack), 1);
        chk("lit_s2_rdata", 32'(cpu_rdata), 32'h33);
      end
    end

    // Continuous misses starve a pending write until video goes quiet
    for (int i = 0; i < 9; i++) begin
      tick(i < 6, (i % 2 == 1) ? 13'h002 : 13'h001);
      if (i == 0) cpu_start(1'b1, 13'h040, 8'h99);
      smp();
      if (i < 6) begin
        chk("lit_s3_no_ack", 32'(cpu_ack), 0);
        chk("lit_s3_no_we", 32'(mem_we), 0);
      end
      if (i == 6) chk("lit_s3_grant_we", 32'(mem_we), 1);
      if (i == 7) chk("lit_s3_ack", 32'(cpu_ack), 1);
    end

    // Write to the cached cell updates the cache; next hit skips the RAM
    tick(1'b1, 13'h010);
    tick(1'b0, '0);
    tick(1'b0, '0);
    cpu_start(1'b1, 13'h010, 8'hC3);
    wait_ack("lit_s4_ack_seen");
    tick(1'b1, 13'h010);
    smp();
    chk("lit_s4_hit_no_ram", 32'(mem_en), 0);
    tick(1'b0, '0);
    tick(1'b0, '0);
    smp();
    chk("lit_s4_vid_valid", 32'(vid_valid), 1);
    chk("lit_s4_vid_data", 32'(vid_data), 32'hC3);

    // Write colliding with a miss fill: miss sees old data, later hit new
    tick(1'b1, 13'h030);
    tick(1'b0, '0);
    cpu_start(1'b1, 13'h030, 8'h77);
    smp();
    chk("lit_s5_grant_we", 32'(mem_we), 1);
    tick(1'b0, '0);
    smp();
    chk("lit_s5_vid_valid", 32'(vid_valid), 1);
    chk("lit_s5_old_data", 32'(vid_data), 32'h11);
    chk("lit_s5_ack", 32'(cpu_ack), 1);
    wait_ack("lit_s5_ack_seen");
    tick(1'b1, 13'h030);
    smp();
    chk("lit_s5_hit_no_ram", 32'(mem_en), 0);
    tick(1'b0, '0);
    tick(1'b0, '0);
    smp();
    chk("lit_s5_new_data", 32'(vid_data), 32'h77);

    // Reset during RD_WAIT drops the read; cache starts empty again
    tick(1'b0, '0);
    cpu_start(1'b0, 13'h020, 8'h00);
    smp();
    chk("lit_s6_grant", 32'(mem_en), 1);
    tick(1'b0, '0);
    sys_rst  = 1'b0;
    cpu_req  = 1'b0;
    cpu_done = 1'b0;
    smp();
    chk("lit_s6_rst_ack", 32'(cpu_ack), 0);
    chk("lit_s6_rst_rdata", 32'(cpu_rdata), 0);
    chk("lit_s6_rst_vid", 32'(vid_data), 0);
    tick(1'b0, '0);
    tick(1'b0, '0); sys_rst = 1'b1;
    tick(1'b1, 13'h010);
    smp();
    chk("lit_s6_first_miss", 32'(mem_en), 1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0);
      smp();
      chk("lit_s6_no_ack", 32'(cpu_ack), 0);
      if (i == 1) chk("lit_s6_vid_data", 32'(vid_data), 32'hC3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/world_map_arbiter.md
Name: world_map_arbiter

Overview:
- Shares one single-port synchronous world-map RAM between the real-time video pixel fetch and a processor-side read/write requester.
- The video fetch has absolute priority, a fixed 2-cycle latency, and is never stalled.
- A one-entry last-cell cache absorbs repeated fetches of the same map cell, which happen because every cell spans several adjacent pixels. The freed slots go to the processor.
- Sits between the pixel fetch logic (which feeds world_pixel to the colorizer) and the world-map RAM.

Parameters:
- AW, 13, map cell address width (80x60 cells fit in 8192).
- DW, 8, cell data width; must equal the world_pixel width.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- sys_rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- vid_req  in  1  video fetch request, single-cycle, may be high every cycle.
- vid_addr  in  AW  video cell address, sampled when vid_req=1.
- vid_valid  out  1  video data valid, exactly 2 cycles after vid_req.
- vid_data  out  DW  video cell data.
- cpu_req  in  1  processor request; held high with stable fields until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  processor address.
- cpu_wdata  in  DW  processor write data.
- cpu_ack  out  1  single-cycle completion pulse.
- cpu_rdata  out  DW  read data; valid while cpu_ack=1 for a read.
- mem_en  out  1  RAM enable, combinational in the issue cycle.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, 1 cycle after mem_en with mem_we=0.

Behaviour:
- Reset: vid_valid=0, vid_data=0, cpu_ack=0, cpu_rdata=0, cache invalid, FSM=IDLE, pipeline flags 0. mem_en=mem_we=0 during reset.
- Video hit: vid_req=1, cache valid and vid_addr==cache_addr. No RAM access is made.
- Video miss: vid_req=1 and not a hit. The RAM read is issued in the same cycle t. cache_addr<=vid_addr and cache_valid<=1 at the end of t.
- Stage register s1 {valid, hit}, written at the end of t. In t+1:
  - If hit: vid_data<=cache_data.
  - If miss: vid_data<=mem_rdata and cache_data<=mem_rdata.
  - vid_valid=1 in t+2 regardless of hit or miss.
- Back-to-back: a miss on A at t followed by a hit on A at t+1 returns the freshly loaded data (the cache is updated at the end of t+1).
- Processor FSM states are IDLE, RD_WAIT, RESP.
- IDLE: the processor is granted in cycle g only when cpu_req=1 and the RAM is not used by a video miss in g.
  - Write: drive mem_we=1, go to RESP.
  - Read: go to RD_WAIT.
  - Otherwise stay in IDLE.
- RD_WAIT: cpu_rdata<=mem_rdata, go to RESP.
- RESP: cpu_ack=1 for one cycle, go to IDLE. cpu_req is ignored in RESP. The requester must drop cpu_req or present a new request in the following cycle.
- Write latency: ack in g+1. Read latency: ack and data in g+2. Video misses may use the RAM during RD_WAIT and RESP.
- Coherence: a granted processor write in g with cpu_addr==cache_addr sets cache_data<=cpu_wdata at the end of g.
  - Video hits issued in g or later return the new value.
  - If the write collides with a miss capture in the same cycle, the write wins for cache_data. The miss itself still returns the pre-write RAM value.
- Starvation: the processor waits indefinitely while every cycle is a video miss. It has no priority boost.
- Asynchronous reset mid-transaction: the pending processor request is dropped with no ack. The requester re-issues it after reset.
- Address compares are full AW bits. Nothing wraps.

Optional Feature:
- ARB_STALL_CNT_EN defined:
  - Adds output stall_count [15:0]. It increments each cycle the FSM is in IDLE with cpu_req=1 and no grant.
  - It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
- Reset release, vid_req=1 with addr 0x010 for 4 consecutive cycles, RAM[0x010]=0x5A -> mem_en high only in the first cycle; vid_valid in cycles 2..5 with vid_data=0x5A each.
- Same 4-cycle hit run while cpu_req read of 0x020 (RAM=0x33) is pending -> grant in the 2nd cycle; cpu_ack 2 cycles later with cpu_rdata=0x33.
- vid_req miss every cycle (alternating 0x001/0x002) with cpu_req write pending -> no grant, cpu_ack stays 0; grant in the first cycle vid_req drops, ack the next cycle.
- Cache holds 0x010=0x5A; processor write 0x010<=0xC3, then video hit on 0x010 -> vid_data=0xC3 with no RAM read.
- Miss on 0x030 at t, processor write 0x030<=0x77 granted at t+1 -> that miss returns the old value; a following hit on 0x030 returns 0x77.
- sys_rst asserted during RD_WAIT -> cpu_ack never pulses, all outputs 0; after release, the first vid_req is a miss.
